reg_file_wb: RTL

- 32 × 32-bit general register file with a registered write-back stage for the RISC datapath.
- Supplies `A_DATA` and `B_DATA` to the operand-select muxes that drive `BUS_A` and `BUS_B`.
- Accepts results from the function unit, from data memory, or from the status flags. The selected result passes through a one-entry write-back register and is then committed to the array.
- After reset, an initialization sequencer clears all registers. Bypass forwarding is optional; when it is compiled out, hazard flags are generated instead.

---
 rtl/reg_file_wb.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/reg_file_wb.sv
// reg_file_wb -- 32 x 32-bit general register file with a one-entry
// registered write-back stage.
//
// After reset an initialization sequencer clears all 32 registers, one per
// clock edge, then raises READY. In RUN, every edge captures the selected
// result into the write-back register and commits the previous write-back
// entry to the array. R0 always reads 0 and is never written.
//
// Build option: define REGFILE_BYPASS_EN to forward the pending write-back
// data to the read ports. Without it, reads return the array contents and
// HAZ_A/HAZ_B flag a read that matches the pending write-back.
//
// Ports:
//   CLK      in   1   clock, rising edge
//   RST_N    in   1   asynchronous active-low reset
//   AA, BA   in   5   read addresses, ports A and B
//   A_DATA   out  32  read data, port A (combinational)
//   B_DATA   out  32  read data, port B (combinational)
//   DA       in   5   destination register address
//   RW       in   1   register write request
//   MD       in   2   result select: 00 F, 01 DATA_IN, 10 N^V, 11 F
//   F        in   32  function-unit result
//   DATA_IN  in   32  data-memory read data
//   N, V     in   1   negative / overflow flags
//   READY    out  1   initialization complete
//   HAZ_A    out  1   port-A address matches pending write-back
//   HAZ_B    out  1   port-B address matches pending write-back
module reg_file_wb (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [4:0]  AA,
  input  logic [4:0]  BA,
  output logic [31:0] A_DATA,
  output logic [31:0] B_DATA,
  input  logic [4:0]  DA,
  input  logic        RW,
  input  logic [1:0]  MD,
  input  logic [31:0] F,
  input  logic [31:0] DATA_IN,
  input  logic        N,
  input  logic        V,
  output logic        READY,
  output logic        HAZ_A,
  output logic        HAZ_B
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        ready_q;
  logic        wb_valid_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic [31:0] regs_q [0:31];

  logic [31:0] wb_data_d;
  logic        wb_valid_d;
  logic        commit_en_s;
  logic [4:0]  commit_addr_s;
  logic [31:0] commit_data_s;
  logic        match_a_s;
  logic        match_b_s;
  logic [31:0] a_data_s;
  logic [31:0] b_data_s;

  // Result select feeding the write-back register.
  always_comb begin
    wb_data_d = F;
    case (MD)
      2'b00:   wb_data_d = F;
      2'b01:   wb_data_d = DATA_IN;
      2'b10:   wb_data_d = {31'b0, N ^ V};
      2'b11:   wb_data_d = F;
      default: wb_data_d = F;
    endcase
  end

  // R0 is never a write target, so a DA of 0 never becomes a pending write.
  always_comb begin
    wb_valid_d = 1'b0;
    if (RW && (DA != 5'd0)) begin
      wb_valid_d = 1'b1;
    end else begin
      wb_valid_d = 1'b0;
    end
  end

  // Sequencer plus write-back capture; INIT drops any write request.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_INIT;
      cnt_q      <= 5'd0;
      ready_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= 5'd0;
      wb_data_q  <= 32'd0;
    end else begin
      case (state_q)
        ST_INIT: begin
          wb_valid_q <= 1'b0;
          if (cnt_q == 5'd31) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
            cnt_q   <= 5'd0;
          end else begin
            cnt_q   <= cnt_q + 5'd1;
          end
        end
        ST_RUN: begin
          ready_q    <= 1'b1;
          wb_valid_q <= wb_valid_d;
          wb_addr_q  <= DA;
          wb_data_q  <= wb_data_d;
        end
        default: begin
          state_q    <= ST_INIT;
          cnt_q      <= 5'd0;
          ready_q    <= 1'b0;
          wb_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Array write port: clearing sweep in INIT, write-back commit in RUN.
  always_comb begin
    commit_en_s   = 1'b0;
    commit_addr_s = 5'd0;
    commit_data_s = 32'd0;
    if (state_q == ST_INIT) begin
      commit_en_s   = 1'b1;
      commit_addr_s = cnt_q;
      commit_data_s = 32'd0;
    end else begin
      commit_en_s   = wb_valid_q;
      commit_addr_s = wb_addr_q;
      commit_data_s = wb_data_q;
    end
  end

  // Register array; contents are defined only by the INIT sweep, so no reset.
  always_ff @(posedge CLK) begin
    if (commit_en_s) begin
      regs_q[commit_addr_s] <= commit_data_s;
    end
  end

  // A read collides with the pending write-back only for a non-zero address.
  always_comb begin
    match_a_s = wb_valid_q && (wb_addr_q == AA) && (AA != 5'd0);
    match_b_s = wb_valid_q && (wb_addr_q == BA) && (BA != 5'd0);
  end

  // Port A read: zero until READY and for R0.
  always_comb begin
    a_data_s = 32'd0;
    if (!ready_q || (AA == 5'd0)) begin
      a_data_s = 32'd0;
`ifdef REGFILE_BYPASS_EN
    end else if (match_a_s) begin
      a_data_s = wb_data_q;
`endif
    end else begin
      a_data_s = regs_q[AA];
    end
  end

  // Port B read: zero until READY and for R0.
  always_comb begin
    b_data_s = 32'd0;
    if (!ready_q || (BA == 5'd0)) begin
      b_data_s = 32'd0;
`ifdef REGFILE_BYPASS_EN
    end else if (match_b_s) begin
      b_data_s = wb_data_q;
`endif
    end else begin
      b_data_s = regs_q[BA];
    end
  end

  assign A_DATA = a_data_s;
  assign B_DATA = b_data_s;
  assign READY  = ready_q;

`ifdef REGFILE_BYPASS_EN
  // Forwarding hides the pending write, so no stall is ever needed.
  assign HAZ_A = 1'b0 & match_a_s;
  assign HAZ_B = 1'b0 & match_b_s;
`else
  assign HAZ_A = ready_q & match_a_s;
  assign HAZ_B = ready_q & match_b_s;
`endif

endmodule
